// File: rtl/pwm_level_gen.sv
// pwm_level_gen: level-to-PWM generator, level sampled once per period; define PWM_CENTER_EN for center-aligned pulses
module pwm_level_gen #(
    parameter int PERIOD    = 500,
    parameter int LW        = 12,
    parameter int MIN_PULSE = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          en,
    input  logic [LW-1:0] l,
    output logic          pwm,
    output logic          period_start,
    output logic [LW-1:0] cnt,
    output logic [LW-1:0] duty_q,
    output logic          sat
);
    localparam logic [LW:0]   PW   = (LW+1)'(PERIOD);
    localparam logic [LW:0]   MW   = (LW+1)'(MIN_PULSE);
    localparam logic [LW-1:0] LAST = LW'(PERIOD - 1);
    logic          run, sat_n, load, pwm_n;
    logic [LW:0]   lx, dc, dn;
    logic [LW-1:0] f, cnt_n, duty_n;
`ifdef PWM_CENTER_EN
    logic [LW-1:0] ofs_q, ofs_n;
`endif
    // duty shaping (clip, min pulse) and next-state values that pwm is derived from
    always_comb begin
        lx     = {1'b0, l};
        sat_n  = lx > PW;
        dc     = sat_n ? PW : lx;
        dn     = (dc != '0 && dc < MW) ? '0 : (dc > PW - MW && dc < PW) ? PW : dc;
        f      = dn[LW-1:0];
        load   = en && (!run || cnt == LAST);
        cnt_n  = load ? '0 : cnt + LW'(1);
        duty_n = load ? f : duty_q;
`ifdef PWM_CENTER_EN
        ofs_n  = load ? LW'((PW - dn) >> 1) : ofs_q;
        pwm_n  = cnt_n >= ofs_n && {1'b0, cnt_n} < {1'b0, ofs_n} + {1'b0, duty_n};
`else
        pwm_n  = cnt_n < duty_n;
`endif
    end
    // period counter, shadow duty load at start/wrap, registered pwm
    always_ff @(posedge clk) begin
        if (nrst) begin
            run          <= 1'b0;
            cnt          <= '0;
            duty_q       <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
            sat          <= 1'b0;
`ifdef PWM_CENTER_EN
            ofs_q        <= '0;
`endif
        end else if (!en) begin
            run          <= 1'b0;
            cnt          <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            run          <= 1'b1;
            cnt          <= cnt_n;
            duty_q       <= duty_n;
            period_start <= load;
            pwm          <= pwm_n;
            if (load) sat <= sat_n;
`ifdef PWM_CENTER_EN
            ofs_q        <= ofs_n;
`endif
        end
    end
endmodule

// File: doc/pwm_level_gen.md
Name: pwm_level_gen

Overview:
- Downstream stage of the level calculator. Converts the 12-bit drive level `l` (0..500 nominal, 0x1F4 full scale) into a fixed-period PWM drive signal for the transmitter LED.
- Samples `l` once per PWM period into a shadow register, so level changes never corrupt a pulse in flight.
- Applies clipping and minimum-pulse rules.
- Exports period/debug status for the link controller and the bench.

Parameters:
- PERIOD, 500, PWM period in clk cycles; full-scale level; legal range 2..4095.
- LW, 12, width of level input, count and duty registers.
- MIN_PULSE, 2, shortest high or low pulse allowed; legal range 1..PERIOD/2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- nrst  in  1  reset, synchronous, active-high (nrst=1 resets on the next clk edge)
- en  in  1  run enable; 0 parks the generator
- l  in  LW  requested level from the level calculator; continuous, no valid strobe
- pwm  out  1  PWM drive, registered
- period_start  out  1  one-cycle pulse in the first cycle of each period (cnt==0)
- cnt  out  LW  current period position 0..PERIOD-1, registered
- duty_q  out  LW  duty in force for the current period, registered
- sat  out  1  1 when the latched level exceeded PERIOD (clipped)

Behaviour:
- Reset (nrst=1): cnt=0, duty_q=0, pwm=0, period_start=0, sat=0, internal run flag=0.
  - nrst has priority over en.
  - Reset mid-period aborts the period immediately.
- Duty function f(l), computed in LW+1 bits so there is no wrap:
  - Clip: if l > PERIOD, d = PERIOD and sat_n = 1; else d = l and sat_n = 0.
  - Min pulse: 0 < d < MIN_PULSE gives d = 0.
  - Min pulse: PERIOD-MIN_PULSE < d < PERIOD gives d = PERIOD.
  - d = 0 and d = PERIOD pass unchanged.
- Edge where en=0 (and nrst=0):
  - run=0, cnt<=0, pwm<=0, period_start<=0.
  - duty_q and sat hold.
  - Effect is visible the next cycle, even mid-period.
- Edge where en=1 and run=0 (start):
  - run<=1, cnt<=0, period_start<=1.
  - duty_q<=f(l), sat<=sat_n.
  - pwm<=(0 < f(l)).
  - The first period therefore begins one cycle after en is first seen high.
- Edge where en=1, run=1, cnt==PERIOD-1 (wrap):
  - Same loads as start: cnt<=0, period_start<=1, duty_q<=f(l), sat<=sat_n.
  - `l` is sampled in the last cycle of the old period.
- Edge where en=1, run=1, cnt<PERIOD-1:
  - cnt<=cnt+1, period_start<=0.
  - duty_q and sat hold.
- Registered-output invariant, every cycle with run=1: pwm == (cnt < duty_q) (edge-aligned).
  - pwm is computed from next-state values so that pwm, cnt and duty_q are mutually consistent in the same cycle.
  - Latency from a level sample to its effect on pwm: 1 cycle.
- Results per period:
  - duty_q=0: pwm stays 0 for the whole period.
  - duty_q=PERIOD: pwm stays 1 for the whole period.
  - Consecutive full-on periods produce no glitch at the wrap.
- Changes of `l` at any point other than the sampling edge have no effect on the current period.
- Simultaneous events: en falling on the wrap cycle means the en=0 rule wins; no period_start is produced.

Optional Feature:
- Macro PWM_CENTER_EN.
- Defined (center-aligned mode):
  - At each load, also latch ofs_q = (PERIOD - f(l)) >> 1.
  - pwm == (cnt >= ofs_q) && (cnt < ofs_q + duty_q).
  - The pulse is centered in the period.
  - Clipping, min-pulse and sampling rules are unchanged.
  - duty_q=PERIOD gives constant 1.
- Undefined: edge-aligned as above; no ofs_q register exists.

Test Plan:
- Reset: hold nrst=1 for 3 cycles with en=1, l=250 -> pwm=0, cnt=0, duty_q=0, sat=0, period_start=0 throughout. Release nrst -> period_start=1 one cycle later, cnt=0, duty_q=250.
- Steady level: l=250, en=1 for 3 periods -> pwm high for cnt 0..249 and low for 250..499 each period; period_start every 500 cycles; exactly 250 high cycles per period.
- Clip and full scale:
  - l=600 -> duty_q=500, sat=1, pwm constant 1 across the wrap.
  - l=0 -> pwm constant 0, sat=0.
- Mid-period change: l=100, switch to l=400 at cnt=200 -> current period is high for cnt 0..99; next period duty_q=400, high for cnt 0..399.
- Min pulse (MIN_PULSE=2):
  - l=1 -> duty_q=0, pwm=0.
  - l=499 -> duty_q=500, pwm constant 1.
  - l=2 -> pwm high for cnt 0..1 only.
  - l=498 -> high for cnt 0..497.
- Enable: drop en at cnt=123 -> next cycle pwm=0, cnt=0, period_start=0, duty_q held. Re-raise en -> period_start=1 the following cycle, cnt=0. With PWM_CENTER_EN, l=100 -> pwm high exactly for cnt 200..299.
